// File: rtl/cabac_neigh_arb_pkg.sv
// Shared constants and types for the CABAC top-neighbour store.
//   PIC_X_WIDTH : CTU column index width (neighbour RAM address width)
//   NEIGH_DW    : width of one neighbour context byte
//   port_op_e   : action taken on the single RAM port in a cycle
package cabac_neigh_arb_pkg;

  localparam int unsigned PIC_X_WIDTH = 6;
  localparam int unsigned NEIGH_DW    = 8;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_READ,
    PORT_DRAIN
  } port_op_e;

endpackage

// File: rtl/cabac_neigh_arb_wbuf.sv
// Write buffer for the neighbour store: circular FIFO of {addr, data} with a
// CAM-style search that returns the newest entry matching a lookup address.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push            : append {push_addr, push_data} at the tail
//   pop             : retire the head entry
//   srch_addr       : lookup address for forwarding
//   full, empty     : occupancy flags
//   head_addr/_data : oldest pending entry
//   hit, hit_data   : newest valid entry matching srch_addr
module cabac_neigh_arb_wbuf
  import cabac_neigh_arb_pkg::*;
#(
  parameter int unsigned AW    = PIC_X_WIDTH,
  parameter int unsigned DW    = NEIGH_DW,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic [AW-1:0] srch_addr,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Walk from oldest to newest; a later match overrides an earlier one so the
  // entry nearest the tail wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_mem[idx] == srch_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/rf_1p.sv
// Single-port register file with active-low chip and write enables and a
// registered read port.
//   clk    : clock
//   cen_i  : chip enable, active low
//   wen_i  : write enable, active low (1 = read when enabled)
//   addr_i : word address
//   data_i : write data
//   data_o : read data, updated on the edge of an enabled read, held otherwise
module rf_1p #(
  parameter int unsigned Addr_Width = 6,
  parameter int unsigned Word_Width = 8
) (
  input  logic                  clk,
  input  logic                  cen_i,
  input  logic                  wen_i,
  input  logic [Addr_Width-1:0] addr_i,
  input  logic [Word_Width-1:0] data_i,
  output logic [Word_Width-1:0] data_o
);

  logic [Word_Width-1:0] mem [2**Addr_Width];

  always_ff @(posedge clk) begin
    if (!cen_i) begin
      if (!wen_i) mem[addr_i] <= data_i;
      else        data_o      <= mem[addr_i];
    end
  end

endmodule

// File: rtl/cabac_neigh_arb.sv
// Arbiter/sequencer for the CABAC top-neighbour store. Shares one RAM port
// between the read requester (priority) and buffered write-back; buffered
// writes drain on cycles without a granted read, and reads hitting a pending
// write are served from the buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_req, rd_addr     : read request / address
//   rd_gnt              : read accepted this cycle (combinational)
//   rd_valid, rd_data   : read result, one cycle after rd_gnt
//   wr_req, wr_addr,
//   wr_data             : write request / address / data
//   wr_gnt              : write accepted this cycle (combinational)
//   wbuf_empty          : no pending writes
module cabac_neigh_arb
  import cabac_neigh_arb_pkg::*;
#(
  parameter int unsigned AW         = PIC_X_WIDTH,
  parameter int unsigned DW         = NEIGH_DW,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic          wbuf_empty
);

  logic          full;
  logic          empty;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          push;
  logic          pop;
  port_op_e      op;

  logic          ram_cen;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;

  logic          hit_r;
  logic [DW-1:0] fwd_r;

  // Grants are forced low while reset is asserted.
  assign wr_gnt = rst_n & ~full;
  assign rd_gnt = rst_n & rd_req & ~full;
  assign push   = wr_req & wr_gnt;

  always_comb begin
    op = PORT_IDLE;
    if (rd_gnt)      op = PORT_READ;
    else if (!empty) op = PORT_DRAIN;
  end

  assign pop      = (op == PORT_DRAIN);
  assign ram_cen  = (op == PORT_IDLE);
  assign ram_wen  = (op != PORT_DRAIN);
  assign ram_addr = (op == PORT_DRAIN) ? head_addr : rd_addr;

  cabac_neigh_arb_wbuf #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .srch_addr (rd_addr),
    .full      (full),
    .empty     (empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  rf_1p #(
    .Addr_Width (AW),
    .Word_Width (DW)
  ) u_ram (
    .clk    (clk),
    .cen_i  (ram_cen),
    .wen_i  (ram_wen),
    .addr_i (ram_addr),
    .data_i (head_data),
    .data_o (ram_dout)
  );

  // The search only sees entries present before this edge, so a write pushed
  // alongside a granted read is ordered after that read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      hit_r    <= 1'b0;
      fwd_r    <= '0;
    end else begin
      rd_valid <= rd_gnt;
      if (rd_gnt) begin
        hit_r <= hit;
        if (hit) fwd_r <= hit_data;
      end
    end
  end

  assign rd_data    = hit_r ? fwd_r : ram_dout;
  assign wbuf_empty = empty;

endmodule

// File: tb/tb_cabac_neigh_arb.sv
module tb_cabac_neigh_arb;

  logic       clk;
  logic       rst_n;
  logic       rd_req;
  logic [5:0] rd_addr;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       wr_req;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_gnt;
  logic       wbuf_empty;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];

  cabac_neigh_arb #(
    .AW         (6),
    .DW         (8),
    .WBUF_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .wbuf_empty (wbuf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      if (sb.size() == 0) chk("rd_valid_unexpected", 32'd1, 32'd0);
      else chk("rd_data", {24'd0, rd_data}, {24'd0, sb.pop_front()});
    end
  end

  // One cycle of stimulus: drive, check grants, queue the expected result.
  task automatic cyc(input logic rr, input logic [5:0] ra,
                     input logic wr, input logic [5:0] wa, input logic [7:0] wd,
                     input logic erg, input logic ewg, input logic [7:0] exp_d);
    @(negedge clk);
    rd_req  = rr;
    rd_addr = ra;
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
    #1;
    chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, erg});
    chk("wr_gnt", {31'd0, wr_gnt}, {31'd0, ewg});
    if (erg) sb.push_back(exp_d);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 6'd0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b1, 8'd0);
  endtask

  initial begin
    logic [7:0] rg_tab [8];
    logic [7:0] wg_tab [8];
    logic [7:0] wv_tab [8];
    rst_n = 1'b0; rd_req = 1'b1; rd_addr = '0; wr_req = 1'b1; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_wbuf_empty", {31'd0, wbuf_empty}, 32'd1);
    chk("rst_rd_gnt", {31'd0, rd_gnt}, 32'd0);
    chk("rst_wr_gnt", {31'd0, wr_gnt}, 32'd0);
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Preload RAM contents used later.
    cyc(0, 0, 1, 9,  8'h99, 0, 1, 0);
    cyc(0, 0, 1, 3,  8'h55, 0, 1, 0);
    cyc(0, 0, 1, 40, 8'h40, 0, 1, 0);
    cyc(0, 0, 1, 20, 8'hA0, 0, 1, 0);
    cyc(0, 0, 1, 21, 8'hA1, 0, 1, 0);
    cyc(0, 0, 1, 22, 8'hA2, 0, 1, 0);
    idle(4);
    #1 chk("empty_after_preload", {31'd0, wbuf_empty}, 32'd1);

    // Write, let it drain, read from RAM.
    cyc(0, 0, 1, 5, 8'h3C, 0, 1, 0);
    idle(2);
    cyc(1, 5, 0, 0, 0, 1, 1, 8'h3C);

    // Read right after write is forwarded.
    cyc(0, 0, 1, 7, 8'hA1, 0, 1, 0);
    cyc(1, 7, 0, 0, 0, 1, 1, 8'hA1);
    idle(3);

    // Continuous reads of 9 while writing twice: old, first new, newest.
    cyc(1, 9, 1, 9, 8'h11, 1, 1, 8'h99);
    cyc(1, 9, 1, 9, 8'h22, 1, 1, 8'h11);
    cyc(1, 9, 0, 0, 0,     1, 1, 8'h22);
    idle(4);

    // Buffer fill under continuous reads: stall, drain, resume.
    rg_tab = '{1, 1, 1, 1, 0, 1, 0, 1};
    wg_tab = '{1, 1, 1, 1, 0, 1, 0, 1};
    wv_tab = '{1, 1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      logic [5:0] a;
      logic [7:0] d;
      a = (i < 4) ? 6'(50 + i) : 6'd54;
      d = (i < 4) ? 8'(8'hD0 + i) : 8'hD4;
      cyc(1, 40, wv_tab[i][0], a, d, rg_tab[i][0], wg_tab[i][0], 8'h40);
      if (i == 6) chk("wbuf_empty_while_full", {31'd0, wbuf_empty}, 32'd0);
    end
    idle(6);
    #1 chk("empty_after_drain", {31'd0, wbuf_empty}, 32'd1);
    for (int i = 0; i < 5; i++) cyc(1, 6'(50 + i), 0, 0, 0, 1, 1, 8'(8'hD0 + i));
    idle(2);

    // Same-cycle read and write to 3: read sees old data.
    cyc(1, 3, 1, 3, 8'h66, 1, 1, 8'h55);
    idle(3);
    cyc(1, 3, 0, 0, 0, 1, 1, 8'h66);
    idle(2);

    // Reset with three buffered writes and a read in flight.
    cyc(1, 40, 1, 20, 8'hB0, 1, 1, 8'h40);
    cyc(1, 40, 1, 21, 8'hB1, 1, 1, 8'h40);
    cyc(1, 40, 1, 22, 8'hB2, 1, 1, 8'h40);
    cyc(1, 40, 0, 0,  0,     1, 1, 8'h40);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    wr_req = 1'b1;
    #1;
    chk("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("midrst_wbuf_empty", {31'd0, wbuf_empty}, 32'd1);
    chk("midrst_rd_gnt", {31'd0, rd_gnt}, 32'd0);
    chk("midrst_wr_gnt", {31'd0, wr_gnt}, 32'd0);
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    rst_n = 1'b1;
    cyc(1, 20, 0, 0, 0, 1, 1, 8'hA0);
    cyc(1, 21, 0, 0, 0, 1, 1, 8'hA1);
    cyc(1, 22, 0, 0, 0, 1, 1, 8'hA2);
    idle(2);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
